mem_responder: RTL
==================

# mem_responder

Memory-side responder for the 8-bit CPU's memory bus. It answers the datapath's read (`membus`) and write (`busmem`) requests addressed by the AR output `memaddr`. It provides on-chip byte storage with a parameterised wait-state sequencer, a one-cycle `ready` strobe, and out-of-range error reporting. It also includes a sequential program-loader port, used while the CPU is held, to fill memory before a run.

## Interface
Parameters:
- `ADDR_W`, default 8: implemented address bits; storage is 2^ADDR_W bytes.
- `WAIT`, default 1: wait states inserted before each access, range 0–15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `memaddr` input 16: byte address from the CPU's AR.
- `membus` input 1: CPU read request (level).
- `busmem` input 1: CPU write request (level).
- `data_out` input 8: write data from the CPU bus.
- `data_in` output 8: read data to the CPU bus.
- `ready` output 1: one-cycle completion strobe.
- `err` output 1: one-cycle strobe marking a faulted request.
- `ld_mode` input 1: loader mode; CPU requests are ignored while high.
- `ld_wr` input 1: loader write strobe.
- `ld_data` input 8: loader byte.
- `ld_ptr` output ADDR_W: next loader address.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- **IDLE**
  - `ld_mode`=0 and exactly one of `membus`/`busmem` high: latch `memaddr`, `data_out` and the request type.
    - Go to WAIT if `WAIT`>0, else ACCESS.
    - Load the wait counter with `WAIT`-1.
  - `membus` and `busmem` both high: no access, no latch. Pulse `err` the next cycle, then go to DONE.
- **WAIT**: decrement the counter each cycle; go to ACCESS on the cycle the counter reads 0.
- **ACCESS**, one cycle:
  - In-range read: `data_in` ← mem[addr].
  - In-range write: mem[addr] ← latched data.
  - Register `ready`=1 for the next cycle, then go to DONE.
  - Out-of-range (`memaddr[15:ADDR_W]`≠0):
    - Read: returns 8'h00.
    - Write: discarded.
    - Pulse `ready` and `err` together so the CPU never hangs.
- **DONE**: wait until `membus`=0 and `busmem`=0, then go to IDLE. Requests held high do not retrigger.
- `data_in` holds its last read value until the next completed read; writes do not change it.
- Address, data and request changes after the latch are ignored until the next IDLE.
- **Loader** (`ld_mode`=1):
  - A 0→1 edge of `ld_mode` clears `ld_ptr` to 0.
  - Each cycle with `ld_wr`=1 writes `ld_data` to mem[`ld_ptr`] and increments `ld_ptr`, wrapping from 2^ADDR_W−1 to 0.
  - `ld_mode` rising while the FSM is not IDLE: the in-flight CPU access completes normally. The loader is blocked until the FSM returns to IDLE; `ld_wr` strobes arriving during that time are dropped.
  - While `ld_mode`=1, IDLE does not accept CPU requests.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - `ready`=0, `err`=0, `data_in`=8'h00, `ld_ptr`=0.
  - FSM in IDLE, wait counter 0.
- Reset asserted mid-access: FSM returns to IDLE on that edge.
  - A write not yet in ACCESS is never performed.
  - `ready` and `err` are 0 the following cycle.
- Latency: with the request first sampled high at edge k, `ready` is high during the cycle after edge k+`WAIT`+1, for exactly one cycle.
  - Read data is valid on `data_in` in the same cycle as `ready`, and thereafter.
  - The write takes effect at the edge that raises `ready`.
- Minimum spacing between back-to-back requests: the request must be low for at least one sampled edge while in DONE.
- Conflict `err` (both requests high): high in the cycle after edge k, with `ready`=0.
- Loader: write and pointer increment occur at the `ld_wr` edge; no `ready` is produced.

## Test plan
- **Reset, then a read at 0x0005 with `WAIT`=1**: `data_in`=8'h00, `ready`=0 after reset; `ready` pulses at edge k+2 with the stored byte, and remains 0 while the request is held.
- **Loader sequence**: `ld_mode`↑, then write 8'hA1, 8'hB2, 8'hC3 → `ld_ptr`=3. CPU reads of 0x0000–0x0002 then return A1, B2, C3.
- **Write 8'h5A to 0x0010, then read 0x0010** → second `ready` carries 8'h5A. Sweep `WAIT`=0 and `WAIT`=3; latency is 1 and 4 cycles respectively.
- **Out-of-range**:
  - Read at 0x0100 (`ADDR_W`=8) → `ready`=`err`=1 for one cycle, `data_in`=8'h00.
  - Write 8'hFF to 0x0100 → mem[0x00] unchanged.
- **Conflict**: `membus`=`busmem`=1 → `err` pulse, no `ready`, no memory change. Also cover the loader pointer wrapping 0xFF→0x00.
- **Reset during WAIT of a write (`WAIT`=3)** → target byte unchanged, FSM idle, and the next request is served with full latency.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: byte memory for the CPU bus with wait states, ready/err strobes, range check and program loader (clk/rst; memaddr, membus, busmem, data_out in; data_in, ready, err out; ld_mode, ld_wr, ld_data in; ld_ptr out)
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       memaddr,
  input  logic              membus,
  input  logic              busmem,
  input  logic [7:0]        data_out,
  output logic [7:0]        data_in,
  output logic              ready,
  output logic              err,
  input  logic              ld_mode,
  input  logic              ld_wr,
  input  logic [7:0]        ld_data,
  output logic [ADDR_W-1:0] ld_ptr
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
  state_t state, state_n;
  logic [7:0] mem [2**ADDR_W];
  logic [15:0] addr_q;
  logic [7:0] wdata_q;
  logic wr_q, ld_q;
  logic [3:0] cnt;
  logic req_one, conflict, oor, ld_rise, ld_do, mem_we;
  logic [ADDR_W-1:0] idx, wa;
  logic [7:0] wd;
  assign req_one = ~ld_mode & (membus ^ busmem);
  assign conflict = ~ld_mode & membus & busmem;
  assign oor = |(addr_q >> ADDR_W);
  assign idx = addr_q[ADDR_W-1:0];
  assign ld_rise = ld_mode & ~ld_q;
  assign ld_do = ld_mode & ld_wr & ~ld_rise & (state == S_IDLE);
  assign mem_we = ~rst & ((state == S_ACCESS & wr_q & ~oor) | ld_do);
  assign wa = ld_do ? ld_ptr : idx;
  assign wd = ld_do ? ld_data : wdata_q;
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE   ? (req_one ? (WAIT > 0 ? S_WAIT : S_ACCESS) : conflict ? S_DONE : S_IDLE)
            : state == S_WAIT   ? (cnt == 4'd0 ? S_ACCESS : S_WAIT)
            : state == S_ACCESS ? S_DONE
            : (membus | busmem) ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      ready <= 1'b0;
      err <= 1'b0;
      data_in <= 8'h00;
      ld_ptr <= '0;
      ld_q <= 1'b0;
      addr_q <= 16'h0000;
      wdata_q <= 8'h00;
      wr_q <= 1'b0;
    end else begin
      ld_q <= ld_mode;
      ready <= state == S_ACCESS;
      err <= (state == S_ACCESS && oor) || (state == S_IDLE && conflict);
      if (state == S_IDLE && req_one) begin
        addr_q <= memaddr;
        wdata_q <= data_out;
        wr_q <= busmem;
        cnt <= WAIT > 0 ? 4'(WAIT - 1) : 4'd0;
      end else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == S_ACCESS && !wr_q) data_in <= oor ? 8'h00 : mem[idx];
      ld_ptr <= ld_rise ? '0 : ld_do ? ld_ptr + 1'b1 : ld_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[wa] <= wd;
  end
endmodule
